alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// Control/operand stage directly upstream of _alu. Accepts 16-bit Hack-format instructions over a
// valid/ready handshake, holds the A and D registers and the PC, reads M from data memory, and
// drives _alu's six control bits and lhs/rhs. It takes alu_result back, writes it to A/D/M and
// resolves jumps. Multi-cycle, one instruction in flight.
// PARAMETERS
// WIDTH     16  datapath width (A, D, M, ALU operands/result)
// ADDR_W    15  PC and memory address width; uses the low ADDR_W bits of A
// RESET_PC  0   PC value after reset
// PORTS
// clk            in   1        single clock, all state changes on posedge
// reset          in   1        synchronous, active-high
// instr_valid    in   1        instr holds a valid instruction
// instr_ready    out  1        stage can accept; high only in FETCH
// instr          in   WIDTH    instruction word
// pc             out  ADDR_W   address of next instruction to fetch
// mem_addr       out  ADDR_W   data memory address = A[ADDR_W-1:0] (pre-instruction A)
// mem_rd_req     out  1        held high in MEM_RD until mem_rvalid
// mem_rvalid     in   1        mem_rdata valid this cycle
// mem_rdata      in   WIDTH    M read data
// mem_wr_req     out  1        held high in MEM_WR until mem_wready
// mem_wdata      out  WIDTH    M write data (latched ALU result)
// mem_wready     in   1        write accepted this cycle
// zero_lhs, invert_lhs, zero_rhs, invert_rhs, opcode, invert_result  out 1 each  _alu controls = IR[11:6]
// alu_lhs        out  WIDTH    = D
// alu_rhs        out  WIDTH    = IR[12] ? M_latched : A
// alu_result     in   WIDTH    combinational _alu output
// a_reg, d_reg   out  WIDTH    architectural registers (debug/verification visibility)
// BEHAVIOUR
// - Reset (synchronous, wins over everything): state<=FETCH, A<=0, D<=0, M_latched<=0, IR<=0, pc<=RESET_PC;
//   mem_rd_req=mem_wr_req=0 and instr_ready=1 from the first cycle after the reset edge. Reset mid-MEM_RD or
//   mid-MEM_WR abandons the request with no partial write to A/D.
// - FETCH: instr_ready=1. On instr_valid&instr_ready: IR<=instr, ->DECODE. No handshake -> stay.
// - DECODE: IR[15]=0 (A-instr): A<=IR (MSB 0), pc<=pc+1, ->FETCH (2-cycle instruction).
//   IR[15]=1 (C-instr): IR[12]=1 ->MEM_RD; else ->EXEC.
// - MEM_RD: mem_rd_req=1, mem_addr=A. On mem_rvalid: M_latched<=mem_rdata, ->EXEC. Unlimited wait.
// - EXEC: ALU controls from IR[11:6]; sample alu_result into R. Dest IR[5:3]=d1 A, d2 D, d3 M.
//   D<=R if d2; A<=R if d1; mem_wdata<=R. Jump: zr=(R==0), ng=R[WIDTH-1];
//   take = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr). pc<=take ? A_old[ADDR_W-1:0] : pc+1
//   (A_old = A before this instruction's write). ->MEM_WR if d3 else ->FETCH.
// - MEM_WR: mem_wr_req=1, mem_addr=A_old latched in EXEC (not the new A), mem_wdata=R. On mem_wready ->FETCH.
// - pc+1 wraps modulo 2^ADDR_W; jump target truncated to ADDR_W bits.
// - C-instr with IR[14:13]!=2'b11 executes identically (bits ignored).
// - Control outputs and alu_lhs/rhs are driven from IR/registers in every state (no X); only EXEC samples R.
// - Latency (zero-wait memory): A-instr 2, C-instr 3, +1 if a=1, +1 if d3.
// STRUCTURE
// - Shared package/header (cpu_defs.vh): state encodings (FETCH, DECODE, MEM_RD, EXEC, MEM_WR), instruction
//   field positions (A_BIT=12, CTRL=11:6, DEST=5:3, JMP=2:0), WIDTH/ADDR_W defaults.
// - One sub-module: jump_cond (alu result, IR[2:0] -> take). Registers and FSM stay in this module;
//   _alu is instantiated alongside it in cpu.v, not inside this block.
// TESTING (bench instantiates this block + _alu + simple memory model)
// - @5, D=A (0xEC10), @20, D=A-D (0xE1D0) -> d_reg=15, a_reg=20, pc=4.
// - @10 then 0;JMP (0xEA87) -> pc=10. @10, D=0 (0xEA90), D;JNE (0xE305) -> pc=next seq (not taken).
// - D=15, @7, M=D (0xE308) -> one mem_wr_req with mem_addr=7, mem_wdata=15; d_reg unchanged.
// - @7, D=M+1 (0xFDD0), mem_rdata=41 after 3 wait cycles -> mem_rd_req held 4 cycles, d_reg=42.
// - AM=D+1 with A=7, D=8 (0xE7E8) -> a_reg=9, write addr=7 data 9 (old-A addressing).
// - Assert reset during MEM_RD -> next cycle mem_rd_req=0, instr_ready=1, pc=RESET_PC, a_reg=d_reg=0.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: FSM encodings, Hack
// instruction field positions and the decoded control/jump field types.
package alu_issue_stage_pkg;

    localparam int WIDTH_DEFAULT  = 16;
    localparam int ADDR_W_DEFAULT = 15;

    // FSM encodings, kept as plain constants for legacy tools
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] MEM_RD = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM_WR = 3'd4;

    // Hack instruction field positions
    localparam int C_BIT   = 15;  // 1 = C-instruction, 0 = A-instruction
    localparam int A_BIT   = 12;  // ALU rhs: 1 = M, 0 = A
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_A  = 5;   // d1
    localparam int DEST_D  = 4;   // d2
    localparam int DEST_M  = 3;   // d3
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    // ALU control bits in IR[11:6] order
    typedef struct packed {
        logic zero_lhs;
        logic invert_lhs;
        logic zero_rhs;
        logic invert_rhs;
        logic opcode;
        logic invert_result;
    } alu_ctrl_t;

    // Jump mask in IR[2:0] order: j1 (<0), j2 (==0), j3 (>0)
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jump_mask_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake and data-memory bus of the ALU issue stage.
// The stage is the master: it requests instructions by pc and owns the
// memory transaction; the slave side is the instruction source plus memory.
interface alu_issue_stage_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
);
    logic              instr_valid;
    logic              instr_ready;
    logic [WIDTH-1:0]  instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rvalid;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_wr_req;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_wready;

    modport master (
        input  instr_valid, instr, mem_rvalid, mem_rdata, mem_wready,
        output instr_ready, pc, mem_addr, mem_rd_req, mem_wr_req, mem_wdata
    );

    modport slave (
        output instr_valid, instr, mem_rvalid, mem_rdata, mem_wready,
        input  instr_ready, pc, mem_addr, mem_rd_req, mem_wr_req, mem_wdata
    );
endinterface

// File: rtl/alu_issue_stage_jump_cond.sv
// Hack jump resolution: decides from the ALU result and the jump mask
// whether the branch is taken.
module alu_issue_stage_jump_cond
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] result,
    input  jump_mask_t       jump,
    output logic             take
);
    logic zr;
    logic ng;

    assign zr   = (result == '0);
    assign ng   = result[WIDTH-1];
    assign take = (jump.lt & ng) | (jump.eq & zr) | (jump.gt & ~ng & ~zr);
endmodule

// File: rtl/alu_issue_stage.sv
// Control/operand stage in front of the Hack ALU. Holds A, D, PC and the
// latched M operand, sequences one instruction at a time through
// FETCH/DECODE/MEM_RD/EXEC/MEM_WR, and writes the ALU result back.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEFAULT,
    parameter int               ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_stage_if.master bus,
    output logic              zero_lhs,
    output logic              invert_lhs,
    output logic              zero_rhs,
    output logic              invert_rhs,
    output logic              opcode,
    output logic              invert_result,
    output logic [WIDTH-1:0]  alu_lhs,
    output logic [WIDTH-1:0]  alu_rhs,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  a_reg,
    output logic [WIDTH-1:0]  d_reg
);
    logic [2:0]        state_q;
    logic [WIDTH-1:0]  ir_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  d_q;
    logic [WIDTH-1:0]  m_q;
    logic [WIDTH-1:0]  r_q;        // ALU result captured in EXEC
    logic [ADDR_W-1:0] wr_addr_q;  // A before EXEC overwrote it
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic              take;
    alu_ctrl_t         ctrl;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign ctrl   = alu_ctrl_t'(ir_q[CTRL_HI:CTRL_LO]);

    alu_issue_stage_jump_cond #(.WIDTH(WIDTH)) u_jump_cond (
        .result (alu_result),
        .jump   (jump_mask_t'(ir_q[JMP_HI:JMP_LO])),
        .take   (take)
    );

    // ALU controls and operands follow IR/registers in every state
    assign zero_lhs      = ctrl.zero_lhs;
    assign invert_lhs    = ctrl.invert_lhs;
    assign zero_rhs      = ctrl.zero_rhs;
    assign invert_rhs    = ctrl.invert_rhs;
    assign opcode        = ctrl.opcode;
    assign invert_result = ctrl.invert_result;
    assign alu_lhs       = d_q;
    assign alu_rhs       = ir_q[A_BIT] ? m_q : a_q;
    assign a_reg         = a_q;
    assign d_reg         = d_q;

    assign bus.instr_ready = (state_q == FETCH);
    assign bus.mem_rd_req  = (state_q == MEM_RD);
    assign bus.mem_wr_req  = (state_q == MEM_WR);
    assign bus.mem_wdata   = r_q;
    assign bus.pc          = pc_q;

    // Memory address: current A, except the write phase uses the pre-EXEC A
    always_comb begin
        // NOTE: default first so every path assigns mem_addr and no latch is inferred.
        bus.mem_addr = a_q[ADDR_W-1:0];
        if (state_q == MEM_WR) begin
            bus.mem_addr = wr_addr_q;
        end
    end

    // Sequencer and architectural register updates
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it is tested inside the block, not in the sensitivity list.
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            m_q       <= '0;
            r_q       <= '0;
            wr_addr_q <= '0;
            pc_q      <= RESET_PC;
        end else begin
            // NOTE: non-blocking updates, so EXEC reads the old A for both the jump target and the write address.
            case (state_q)
                FETCH: begin
                    if (bus.instr_valid) begin
                        ir_q    <= bus.instr;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir_q[C_BIT]) begin
                        a_q     <= ir_q;
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end else if (ir_q[A_BIT]) begin
                        state_q <= MEM_RD;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                MEM_RD: begin
                    if (bus.mem_rvalid) begin
                        m_q     <= bus.mem_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    r_q       <= alu_result;
                    wr_addr_q <= a_q[ADDR_W-1:0];
                    if (ir_q[DEST_A]) a_q <= alu_result;
                    if (ir_q[DEST_D]) d_q <= alu_result;
                    pc_q    <= take ? a_q[ADDR_W-1:0] : pc_inc;
                    state_q <= ir_q[DEST_M] ? MEM_WR : FETCH;
                end
                MEM_WR: begin
                    if (bus.mem_wready) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: Hack ALU model, simple memory with
// programmable read wait, hand-computed expectations.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(16), .ADDR_W(15)) bus ();

    logic        zero_lhs, invert_lhs, zero_rhs, invert_rhs, opcode, invert_result;
    logic [15:0] alu_lhs, alu_rhs, alu_result, a_reg, d_reg;

    alu_issue_stage #(.WIDTH(16), .ADDR_W(15), .RESET_PC(15'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .zero_lhs      (zero_lhs),
        .invert_lhs    (invert_lhs),
        .zero_rhs      (zero_rhs),
        .invert_rhs    (invert_rhs),
        .opcode        (opcode),
        .invert_result (invert_result),
        .alu_lhs       (alu_lhs),
        .alu_rhs       (alu_rhs),
        .alu_result    (alu_result),
        .a_reg         (a_reg),
        .d_reg         (d_reg)
    );

    // Hack ALU reference
    logic [15:0] alu_x, alu_y, alu_f;
    always_comb begin
        alu_x = zero_lhs ? 16'h0000 : alu_lhs;
        alu_x = invert_lhs ? ~alu_x : alu_x;
        alu_y = zero_rhs ? 16'h0000 : alu_rhs;
        alu_y = invert_rhs ? ~alu_y : alu_y;
        alu_f = opcode ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_result = invert_result ? ~alu_f : alu_f;
    end

    // Memory model: read data from a fixed image, reads answered after rd_wait cycles
    logic [15:0] mem_img [0:63];
    int rd_wait = 0;
    int rd_cnt = 0;
    int rd_cycles = 0;
    int wr_count = 0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    assign bus.mem_rvalid = bus.mem_rd_req && (rd_cnt >= rd_wait);
    assign bus.mem_rdata  = mem_img[bus.mem_addr[5:0]];
    assign bus.mem_wready = bus.mem_wr_req;

    always @(posedge clk) begin
        if (bus.mem_rd_req && !bus.mem_rvalid) rd_cnt <= rd_cnt + 1;
        else rd_cnt <= 0;
        if (bus.mem_rd_req) rd_cycles <= rd_cycles + 1;
        if (bus.mem_wr_req && bus.mem_wready) begin
            wr_count <= wr_count + 1;
            wr_addr  <= bus.mem_addr;
            wr_data  <= bus.mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int lat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction, wait for the stage to return to FETCH; lat = cycles used
    task automatic issue(input logic [15:0] word);
        int n;
        n = 0;
        while (!bus.instr_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        lat = 1;
        while (!bus.instr_ready && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check("instr_done", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, r0;
        foreach (mem_img[i]) mem_img[i] = 16'h0000;
        mem_img[7] = 16'd41;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("rst_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);
        check("rst_wrreq", {31'd0, bus.mem_wr_req}, 32'd0);
        check("rst_pc", {17'd0, bus.pc}, 32'd0);
        check("rst_a", {16'd0, a_reg}, 32'd0);
        check("rst_d", {16'd0, d_reg}, 32'd0);
        reset = 1'b0;

        // @5, D=A, @20, D=A-D
        issue(16'h0005);
        check("a_instr_lat", lat, 2);
        issue(16'hEC10);
        check("c_instr_lat", lat, 3);
        issue(16'h0014);
        issue(16'hE1D0);
        check("sub_d", {16'd0, d_reg}, 32'd15);
        check("sub_a", {16'd0, a_reg}, 32'd20);
        check("sub_pc", {17'd0, bus.pc}, 32'd4);

        // @10, 0;JMP (taken)
        issue(16'h000A);
        issue(16'hEA87);
        check("jmp_pc", {17'd0, bus.pc}, 32'd10);

        // @10, D=0, D;JNE (not taken)
        issue(16'h000A);
        issue(16'hEA90);
        issue(16'hE305);
        check("jne_pc", {17'd0, bus.pc}, 32'd13);

        // D=15, @7, M=D
        issue(16'h000F);
        issue(16'hEC10);
        issue(16'h0007);
        w0 = wr_count;
        issue(16'hE308);
        check("mwr_lat", lat, 4);
        check("mwr_count", wr_count - w0, 1);
        check("mwr_addr", {17'd0, wr_addr}, 32'd7);
        check("mwr_data", {16'd0, wr_data}, 32'd15);
        check("mwr_d", {16'd0, d_reg}, 32'd15);
        check("mwr_pc", {17'd0, bus.pc}, 32'd17);

        // @7, D=M+1 with 3 wait cycles on the read
        rd_wait = 3;
        issue(16'h0007);
        r0 = rd_cycles;
        issue(16'hFDD0);
        check("mrd_req_cycles", rd_cycles - r0, 4);
        check("mrd_lat", lat, 7);
        check("mrd_d", {16'd0, d_reg}, 32'd42);
        rd_wait = 0;

        // D=8, @7, AM=D+1: write goes to the old A
        issue(16'h0008);
        issue(16'hEC10);
        issue(16'h0007);
        w0 = wr_count;
        issue(16'hE7E8);
        check("am_a", {16'd0, a_reg}, 32'd9);
        check("am_d", {16'd0, d_reg}, 32'd8);
        check("am_count", wr_count - w0, 1);
        check("am_addr", {17'd0, wr_addr}, 32'd7);
        check("am_data", {16'd0, wr_data}, 32'd9);
        check("am_pc", {17'd0, bus.pc}, 32'd23);

        // @30, A=D+1;JMP: target is the old A
        issue(16'h001E);
        issue(16'hE7E7);
        check("ajmp_a", {16'd0, a_reg}, 32'd9);
        check("ajmp_pc", {17'd0, bus.pc}, 32'd30);

        // @3, D=A with IR[14:13]=00 behaves as a normal C-instruction
        issue(16'h0003);
        issue(16'h8C10);
        check("ign_bits_d", {16'd0, d_reg}, 32'd3);
        check("ign_bits_pc", {17'd0, bus.pc}, 32'd32);

        // D=-1, @40, D;JLT (taken)
        issue(16'hEE90);
        check("neg_d", {16'd0, d_reg}, 32'h0000FFFF);
        issue(16'h0028);
        issue(16'hE304);
        check("jlt_pc", {17'd0, bus.pc}, 32'd40);

        // A=D (0xFFFF), 0;JMP -> target truncated to 0x7FFF, then pc+1 wraps
        issue(16'hE320);
        check("a_full", {16'd0, a_reg}, 32'h0000FFFF);
        issue(16'hEA87);
        check("trunc_pc", {17'd0, bus.pc}, 32'h00007FFF);
        issue(16'h0001);
        check("wrap_pc", {17'd0, bus.pc}, 32'd0);

        // Reset while a read is outstanding
        rd_wait = 1000;
        issue(16'h0007);
        while (!bus.instr_ready) begin
            @(posedge clk); #1;
        end
        bus.instr       = 16'hFDD0;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("mid_rst_pc", {17'd0, bus.pc}, 32'd0);
        check("mid_rst_a", {16'd0, a_reg}, 32'd0);
        check("mid_rst_d", {16'd0, d_reg}, 32'd0);
        rd_wait = 0;

        // Stage runs normally after the reset
        issue(16'h0005);
        check("post_rst_a", {16'd0, a_reg}, 32'd5);
        check("post_rst_pc", {17'd0, bus.pc}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
